// File: rtl/riscv_dmem_bridge_if.sv
// Signal bundle between the pipeline MEM-stage data port, the bridge and the
// word-wide data bus.
//   slave  : the bridge's view. It serves the core port and drives the bus
//            request side.
//   master : the environment's view. It is the core plus the bus target.
// Core side : ireq_rd, ireq_wr, iaddr, isize, iunsigned, iwr_data (to bridge)
//             ordata, ostall, omisalign, oerr (from bridge)
// Bus side  : obus_req, obus_we, obus_addr, obus_be, obus_wdata (from bridge)
//             ibus_gnt, ibus_rvalid, ibus_rdata (to bridge)
interface riscv_dmem_bridge_if;
    logic        ireq_rd;
    logic        ireq_wr;
    logic [31:0] iaddr;
    logic [1:0]  isize;
    logic        iunsigned;
    logic [31:0] iwr_data;
    logic [31:0] ordata;
    logic        ostall;
    logic        omisalign;
    logic        oerr;
    logic        obus_req;
    logic        obus_we;
    logic [31:0] obus_addr;
    logic [3:0]  obus_be;
    logic [31:0] obus_wdata;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;

    modport slave (
        input  ireq_rd, ireq_wr, iaddr, isize, iunsigned, iwr_data,
        output ordata, ostall, omisalign, oerr,
        output obus_req, obus_we, obus_addr, obus_be, obus_wdata,
        input  ibus_gnt, ibus_rvalid, ibus_rdata
    );

    modport master (
        output ireq_rd, ireq_wr, iaddr, isize, iunsigned, iwr_data,
        input  ordata, ostall, omisalign, oerr,
        input  obus_req, obus_we, obus_addr, obus_be, obus_wdata,
        output ibus_gnt, ibus_rvalid, ibus_rdata
    );
endinterface

// File: rtl/riscv_dmem_bridge.sv
// Data-memory bridge between the pipeline MEM stage and a req/gnt/rvalid word bus.
// Every core load or store becomes one bus transaction. The core is stalled until
// that transaction completes. The bridge generates the byte enables and the
// lane-aligned store data, and it extracts and extends the load data. Misaligned
// accesses complete without any bus access. Accesses that wait on the bus for
// too long complete with an error.
// Ports:
//   iclk  : clock, all state changes on the rising edge
//   irst  : asynchronous active-high reset
//   dif   : riscv_dmem_bridge_if.slave (core port plus bus request side)
`ifndef RISCV_BIG_ENDIAN
`define RISCV_BIG_ENDIAN 1
`endif
`ifndef RISCV_LITTLE_ENDIAN
`define RISCV_LITTLE_ENDIAN 0
`endif

module riscv_dmem_bridge #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ENDIANESS  = `RISCV_BIG_ENDIAN,
    parameter int MP_TIMEOUT    = 255
) (
    input  logic                  iclk,
    input  logic                  irst,
    riscv_dmem_bridge_if.slave    dif
);
    localparam int DW  = MP_DATA_WIDTH;
    // The counter runs from 0 to MP_TIMEOUT-1. The access aborts on the waiting cycle that finds it at the last value.
    localparam int CW  = (MP_TIMEOUT < 2) ? 1 : $clog2(MP_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MP_TIMEOUT - 1);
    localparam bit BIG = (MP_ENDIANESS == `RISCV_BIG_ENDIAN);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            bus_req_reg, bus_req_next;
    logic [DW-1:0]   rdata_reg, rdata_next;
    logic            misalign_reg, misalign_next;
    logic            err_reg, err_next;
    logic            load_cmd;

    // These hold the attributes of the transaction in flight. They are captured in IDLE only.
    logic            we_reg;
    logic            word_reg;
    logic            half_reg;
    logic            uns_reg;
    logic [1:0]      lane_reg;
    logic            half_hi_reg;
    logic [31:0]     bus_addr_reg;
    logic [3:0]      bus_be_reg;
    logic [DW-1:0]   bus_wdata_reg;

    // Decode of the request as it stands in IDLE.
    logic            req_any;
    logic            is_word_in;
    logic            is_half_in;
    logic            misalign_in;
    logic [1:0]      lane_in;
    logic            half_hi_in;
    logic [3:0]      be_in;
    logic [DW-1:0]   wdata_in;

    assign req_any     = dif.ireq_rd | dif.ireq_wr;
    assign is_word_in  = dif.isize[1];               // 11 behaves as a word access
    assign is_half_in  = (dif.isize == 2'b01);
    assign misalign_in = (is_half_in & dif.iaddr[0]) |
                         (is_word_in & (dif.iaddr[1:0] != 2'b00));
    // Big-endian reverses the lane order (lane = 3 - addr[1:0]).
    assign lane_in     = BIG ? ~dif.iaddr[1:0] : dif.iaddr[1:0];
    // Selects which half of the word the halfword uses: 1 = upper lanes 3:2.
    assign half_hi_in  = BIG ? ~dif.iaddr[1] : dif.iaddr[1];

    always_comb begin
        be_in = 4'b0001 << lane_in;
        if (is_word_in) begin
            be_in = 4'b1111;
        end else if (is_half_in) begin
            be_in = half_hi_in ? 4'b1100 : 4'b0011;
        end
    end

    // Each enabled lane takes its byte from the right-aligned store data.
    // A halfword puts data byte 0 in the even lane and data byte 1 in the odd
    // lane. In both byte orders this places the high byte at the correct address.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] src;
        assign src = is_word_in ? dif.iwr_data[8*gi +: 8] :
                     is_half_in ? dif.iwr_data[8*(gi%2) +: 8] :
                                  dif.iwr_data[7:0];
        assign wdata_in[8*gi +: 8] = be_in[gi] ? src : 8'h00;
    end

    // Load extraction uses the lanes that were captured for the access.
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] load_ext;

    assign ld_byte = dif.ibus_rdata[{lane_reg, 3'b000} +: 8];
    assign ld_half = half_hi_reg ? dif.ibus_rdata[31:16] : dif.ibus_rdata[15:0];

    always_comb begin
        load_ext = dif.ibus_rdata;
        if (!word_reg) begin
            if (half_reg) begin
                load_ext = {{16{~uns_reg & ld_half[15]}}, ld_half};
            end else begin
                load_ext = {{24{~uns_reg & ld_byte[7]}}, ld_byte};
            end
        end
    end

    // The result registers default to zero. They therefore carry data only in
    // the single DONE cycle that follows the transition setting them.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bus_req_next  = bus_req_reg;
        rdata_next    = '0;
        misalign_next = 1'b0;
        err_next      = 1'b0;
        load_cmd      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_any) begin
                    if (misalign_in) begin
                        misalign_next = 1'b1;
                        state_next    = DONE;
                    end else begin
                        load_cmd     = 1'b1;
                        bus_req_next = 1'b1;
                        cnt_next     = '0;
                        state_next   = REQ;
                    end
                end
            end
            REQ: begin
                if (dif.ibus_gnt) begin
                    bus_req_next = 1'b0;
                    state_next   = we_reg ? DONE : WAIT_R;
                end else if (cnt_reg == CNT_LAST) begin
                    bus_req_next = 1'b0;
                    err_next     = 1'b1;
                    state_next   = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WAIT_R: begin
                if (dif.ibus_rvalid) begin
                    rdata_next = load_ext;
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bus_req_reg  <= 1'b0;
            rdata_reg    <= '0;
            misalign_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bus_req_reg  <= bus_req_next;
            rdata_reg    <= rdata_next;
            misalign_reg <= misalign_next;
            err_reg      <= err_next;
        end
    end

    // A store wins when both request lines are high.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            we_reg        <= 1'b0;
            word_reg      <= 1'b0;
            half_reg      <= 1'b0;
            uns_reg       <= 1'b0;
            lane_reg      <= 2'b00;
            half_hi_reg   <= 1'b0;
            bus_addr_reg  <= '0;
            bus_be_reg    <= '0;
            bus_wdata_reg <= '0;
        end else if (load_cmd) begin
            we_reg        <= dif.ireq_wr;
            word_reg      <= is_word_in;
            half_reg      <= is_half_in;
            uns_reg       <= dif.iunsigned;
            lane_reg      <= lane_in;
            half_hi_reg   <= half_hi_in;
            bus_addr_reg  <= {dif.iaddr[31:2], 2'b00};
            bus_be_reg    <= be_in;
            bus_wdata_reg <= dif.ireq_wr ? wdata_in : '0;
        end
    end

    assign dif.ostall     = req_any & (state_reg != DONE);
    assign dif.ordata     = rdata_reg;
    assign dif.omisalign  = misalign_reg;
    assign dif.oerr       = err_reg;
    assign dif.obus_req   = bus_req_reg;
    assign dif.obus_we    = we_reg;
    assign dif.obus_addr  = bus_addr_reg;
    assign dif.obus_be    = bus_be_reg;
    assign dif.obus_wdata = bus_wdata_reg;
endmodule

// File: tb/tb_riscv_dmem_bridge.sv
// Bench for riscv_dmem_bridge. It runs a big-endian instance and a
// little-endian instance side by side. Both instances have MP_TIMEOUT=4. They
// receive identical core and bus stimulus, and each one is checked against a
// byte-addressed memory-order model.
`ifndef RISCV_BIG_ENDIAN
`define RISCV_BIG_ENDIAN 1
`endif
`ifndef RISCV_LITTLE_ENDIAN
`define RISCV_LITTLE_ENDIAN 0
`endif

module tb_riscv_dmem_bridge;
    localparam int TMO = 4;

    logic clk;
    logic irst;
    int   tests = 0;
    int   fails = 0;
    int   txn_id = 0;

    riscv_dmem_bridge_if if_b ();
    riscv_dmem_bridge_if if_l ();

    riscv_dmem_bridge #(.MP_DATA_WIDTH(32), .MP_ENDIANESS(`RISCV_BIG_ENDIAN), .MP_TIMEOUT(TMO))
        dut_b (.iclk(clk), .irst(irst), .dif(if_b));
    riscv_dmem_bridge #(.MP_DATA_WIDTH(32), .MP_ENDIANESS(`RISCV_LITTLE_ENDIAN), .MP_TIMEOUT(TMO))
        dut_l (.iclk(clk), .irst(irst), .dif(if_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_core(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [1:0] size, input logic uns, input logic [31:0] wd);
        if_b.ireq_wr = wr;  if_b.ireq_rd = rd;  if_b.iaddr = addr;
        if_b.isize = size;  if_b.iunsigned = uns;  if_b.iwr_data = wd;
        if_l.ireq_wr = wr;  if_l.ireq_rd = rd;  if_l.iaddr = addr;
        if_l.isize = size;  if_l.iunsigned = uns;  if_l.iwr_data = wd;
    endtask

    task automatic drive_bus(input logic gnt, input logic rv, input logic [31:0] rdata);
        if_b.ibus_gnt = gnt;  if_b.ibus_rvalid = rv;  if_b.ibus_rdata = rdata;
        if_l.ibus_gnt = gnt;  if_l.ibus_rvalid = rv;  if_l.ibus_rdata = rdata;
    endtask

    // Memory-order model. Byte i of the access lives at address addr+i. In
    // big-endian order the most significant byte of the value is at the lowest
    // address. The bus lane that holds a byte address k is 3-k for big-endian
    // and k for little-endian.
    function automatic void model(input bit big, input logic [1:0] size, input logic [31:0] addr,
                                  input logic uns, input logic [31:0] wd, input logic [31:0] rd,
                                  output logic [3:0] be, output logic [31:0] wdata,
                                  output logic [31:0] ld);
        int         n;
        logic [1:0] k;
        logic [1:0] ln;
        logic [7:0] b;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        be = '0;
        wdata = '0;
        ld = '0;
        for (int i = 0; i < n; i++) begin
            k  = addr[1:0] + 2'(i);
            ln = big ? (2'd3 - k) : k;
            be[ln] = 1'b1;
            b = big ? 8'(wd >> (8 * (n - 1 - i))) : 8'(wd >> (8 * i));
            wdata[8*int'(ln) +: 8] = b;
            b = 8'(rd >> (8 * int'(ln)));
            if (big) ld = (ld << 8) | 32'(b);
            else     ld = ld | (32'(b) << (8 * i));
        end
        if (!uns && n < 4 && ld[8*n-1]) ld = ld | (32'hFFFF_FFFF << (8 * n));
    endfunction

    // Runs one core access to completion. gdly is the number of request cycles
    // without a grant before the grant arrives; -1 means the grant never arrives.
    // rdly is the number of cycles after the grant before rvalid.
    task automatic run_txn(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [1:0] size, input logic uns, input logic [31:0] wd,
                           input logic [31:0] rdat, input int gdly, input int rdly);
        logic [3:0]  be_b, be_l;
        logic [31:0] wd_b, wd_l, ld_b, ld_l, rdv;
        logic        g, rv;
        bit          misal, tmo, is_wr;
        int          n, exp_stall, req_last;
        string       p;
        n      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        misal  = (int'(addr[1:0]) % n) != 0;
        is_wr  = wr;
        tmo    = !misal && (gdly < 0);
        model(1'b1, size, addr, uns, wd, rdat, be_b, wd_b, ld_b);
        model(1'b0, size, addr, uns, wd, rdat, be_l, wd_l, ld_l);
        if (misal || tmo || is_wr) begin
            ld_b = '0;
            ld_l = '0;
        end
        exp_stall = misal ? 1 : tmo ? 1 + TMO : is_wr ? gdly + 2 : gdly + rdly + 3;
        req_last  = tmo ? TMO : gdly + 1;
        p = $sformatf("t%0d", txn_id);

        @(negedge clk);
        drive_core(wr, rd, addr, size, uns, wd);
        for (int c = 0; c <= exp_stall; c++) begin
            if (c > 0) @(negedge clk);
            g   = !misal && !tmo && (c == gdly + 1);
            rv  = 1'b0;
            rdv = $urandom;
            if (!is_wr && !misal) begin
                if (!tmo && c == gdly + rdly + 2) begin
                    rv  = 1'b1;
                    rdv = rdat;
                end else if (c >= 1 && c <= req_last) begin
                    rv = 1'($urandom_range(0, 1));   // rvalid noise that arrives before the grant
                end
            end
            drive_bus(g, rv, rdv);
            #1;
            check({p, $sformatf(" b.ostall c%0d", c)}, 32'(if_b.ostall), 32'(c < exp_stall));
            check({p, $sformatf(" l.ostall c%0d", c)}, 32'(if_l.ostall), 32'(c < exp_stall));
            check({p, $sformatf(" b.req c%0d", c)}, 32'(if_b.obus_req),
                  32'(!misal && c >= 1 && c <= req_last));
            check({p, $sformatf(" l.req c%0d", c)}, 32'(if_l.obus_req),
                  32'(!misal && c >= 1 && c <= req_last));
            if (!misal && c == 1) begin
                check({p, " b.addr"}, if_b.obus_addr, {addr[31:2], 2'b00});
                check({p, " l.addr"}, if_l.obus_addr, {addr[31:2], 2'b00});
                check({p, " b.we"}, 32'(if_b.obus_we), 32'(is_wr));
                check({p, " b.be"}, 32'(if_b.obus_be), 32'(be_b));
                check({p, " l.be"}, 32'(if_l.obus_be), 32'(be_l));
                if (is_wr) begin
                    check({p, " b.wdata"}, if_b.obus_wdata, wd_b);
                    check({p, " l.wdata"}, if_l.obus_wdata, wd_l);
                end
            end
            if (c == exp_stall) begin
                check({p, " b.ordata"}, if_b.ordata, ld_b);
                check({p, " l.ordata"}, if_l.ordata, ld_l);
                check({p, " b.misalign"}, 32'(if_b.omisalign), 32'(misal));
                check({p, " l.misalign"}, 32'(if_l.omisalign), 32'(misal));
                check({p, " b.err"}, 32'(if_b.oerr), 32'(tmo));
                check({p, " l.err"}, 32'(if_l.oerr), 32'(tmo));
            end
        end
        drive_core(1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
        drive_bus(1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        check({p, " b.ordata_after"}, if_b.ordata, 32'h0);
        check({p, " b.flags_after"}, {30'd0, if_b.omisalign, if_b.oerr}, 32'h0);
        check({p, " l.req_after"}, 32'(if_l.obus_req), 32'h0);
        $display("[TB] txn %0d %s addr=%h size=%0d uns=%0d gdly=%0d rdly=%0d stall=%0d ordata_b=%h ordata_l=%h",
                 txn_id, is_wr ? "ST" : "LD", addr, size, uns, gdly, rdly, exp_stall, ld_b, ld_l);
        txn_id++;
    endtask

    initial begin
        logic        r_wr, r_rd, r_uns;
        logic [1:0]  r_size;
        int          r_g, r_r;
        irst = 1'b1;
        drive_core(1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
        drive_bus(1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        check("rst b.req", 32'(if_b.obus_req), 32'h0);
        check("rst l.req", 32'(if_l.obus_req), 32'h0);
        check("rst b.addr", if_b.obus_addr, 32'h0);
        check("rst b.be", 32'(if_b.obus_be), 32'h0);
        check("rst b.ordata", if_b.ordata, 32'h0);
        check("rst b.stall", 32'(if_b.ostall), 32'h0);
        @(negedge clk);
        irst = 1'b0;

        // Directed cases.
        run_txn(1'b1, 1'b0, 32'h0000_0104, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_txn(1'b0, 1'b1, 32'h0000_0201, 2'b00, 1'b0, 32'h0, 32'h11F2_3344, 0, 0);
        run_txn(1'b0, 1'b1, 32'h0000_0201, 2'b00, 1'b1, 32'h0, 32'h11F2_3344, 0, 0);
        run_txn(1'b1, 1'b0, 32'h0000_0003, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0, 0, 0);
        run_txn(1'b0, 1'b1, 32'h0000_0040, 2'b10, 1'b0, 32'h0, 32'h1234_5678, -1, 0);
        run_txn(1'b0, 1'b1, 32'h0000_0502, 2'b01, 1'b0, 32'h0, 32'h8899_AABB, 2, 1);
        run_txn(1'b1, 1'b1, 32'h0000_0611, 2'b00, 1'b0, 32'h0000_00A5, 32'h0, 1, 0);
        run_txn(1'b0, 1'b1, 32'h0000_0702, 2'b11, 1'b0, 32'h0, 32'h0, 0, 0);

        // Reset while a load waits for data. The captured bus outputs clear at once.
        @(negedge clk);
        drive_core(1'b0, 1'b1, 32'h0000_0300, 2'b10, 1'b0, '0);
        drive_bus(1'b0, 1'b0, '0);
        @(negedge clk);
        drive_bus(1'b1, 1'b0, '0);
        @(negedge clk);
        drive_bus(1'b0, 1'b0, '0);
        #1;
        check("rstw b.addr_pre", if_b.obus_addr, 32'h0000_0300);
        check("rstw b.stall_pre", 32'(if_b.ostall), 32'h1);
        irst = 1'b1;
        #1;
        check("rstw b.addr", if_b.obus_addr, 32'h0);
        check("rstw l.be", 32'(if_l.obus_be), 32'h0);
        drive_core(1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
        @(negedge clk);
        irst = 1'b0;

        // Reset while a store waits for its grant. The request drops at once.
        @(negedge clk);
        drive_core(1'b1, 1'b0, 32'h0000_0404, 2'b10, 1'b0, 32'h1234_5678);
        @(negedge clk);
        #1;
        check("rstq b.req_pre", 32'(if_b.obus_req), 32'h1);
        irst = 1'b1;
        #1;
        check("rstq b.req", 32'(if_b.obus_req), 32'h0);
        check("rstq l.req", 32'(if_l.obus_req), 32'h0);
        check("rstq b.we", 32'(if_b.obus_we), 32'h0);
        drive_core(1'b0, 1'b0, '0, 2'b00, 1'b0, '0);
        @(negedge clk);
        irst = 1'b0;
        run_txn(1'b1, 1'b0, 32'h0000_0806, 2'b01, 1'b0, 32'h0000_C3D4, 32'h0, 0, 0);

        // Randomized accesses. The wait delays stay within the shared timeout budget.
        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_rd   = 1'($urandom_range(0, 1));
            if (!r_wr && !r_rd) r_rd = 1'b1;
            r_size = 2'($urandom_range(0, 3));
            r_uns  = 1'($urandom_range(0, 1));
            r_g    = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 2));
            r_r    = (r_g < 0) ? 0 : int'($urandom_range(0, 3 - r_g));
            run_txn(r_wr, r_rd, $urandom, r_size, r_uns, $urandom, $urandom, r_g, r_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
